fifo_rd_stream: RTL and testbench
=================================

FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning data width in bits; it SHALL match the data width of the upstream sync_fifo.
REQ-002 clk  input  1  single clock, rising-edge active.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 fifo_empty  input  1  empty flag from the upstream sync_fifo.
REQ-005 fifo_dout  input  DW  upstream sync_fifo read data, valid on the cycle after the pop cycle.
REQ-006 fifo_pop  output  1  pop strobe to the upstream sync_fifo.
REQ-007 m_valid  output  1  stream data valid.
REQ-008 m_ready  input  1  stream consumer ready.
REQ-009 m_data  output  DW  stream data, always the head entry of the buffer.
REQ-010 level  output  2  number of entries held in the buffer, 0..3.
REQ-011 beat_cnt  output  16  accepted-beat count; this port SHALL exist only when FIFO_RD_STREAM_CNT_EN is defined.

Function
REQ-012 The block SHALL convert the pop/empty read interface of sync_fifo into a valid/ready stream through a 3-entry in-order buffer.
REQ-013 The block SHALL keep a registered in-flight flag, infl, which SHALL equal fifo_pop of the previous cycle.
REQ-014 fifo_pop SHALL be 1 exactly when fifo_empty=0 and level+infl<3; it SHALL depend only on registers and fifo_empty, with no path from m_ready.
REQ-015 When infl=1, fifo_dout SHALL be written to the buffer tail in that cycle.
REQ-016 A handshake SHALL occur in any cycle with m_valid=1 and m_ready=1; the handshake SHALL remove the head entry at that clock edge.
REQ-017 m_valid SHALL equal (level!=0) and SHALL be driven from registers only.
REQ-018 A simultaneous write and handshake SHALL leave level unchanged and SHALL preserve order.
REQ-019 A write into an empty buffer SHALL be visible on m_data/m_valid in the next cycle.
REQ-020 Total latency SHALL be 2 cycles: pop cycle N, data captured at end of cycle N+1, m_valid=1 in cycle N+2.
REQ-021 Sustained throughput SHALL be 1 beat per cycle while the FIFO is non-empty and m_ready=1.
REQ-022 m_data SHALL hold stable while m_valid=1 and m_ready=0.
REQ-023 The buffer SHALL never overflow; the level+infl<=3 invariant SHALL hold in every cycle.
REQ-024 Any pointer or index into the buffer SHALL wrap modulo 3.
REQ-025 If the FIFO empties, popping SHALL stop without error, and the buffered entries SHALL drain normally.

Reset
REQ-026 When rstn=0, the following SHALL clear immediately: level=0, infl=0, m_valid=0, m_data=0, fifo_pop=0, and beat_cnt=0 when present.
REQ-027 When reset is asserted mid-operation, buffered entries SHALL be discarded.
REQ-028 When reset is asserted mid-operation, a pop issued in the previous cycle SHALL be discarded and its data SHALL NOT be captured after reset release.
REQ-029 The first pop after reset release SHALL occur no earlier than the first rising edge with rstn=1.

Configuration
REQ-030 When FIFO_RD_STREAM_CNT_EN is defined, beat_cnt SHALL increment by 1 on each handshake and SHALL wrap from 0xFFFF to 0x0000.
REQ-031 When FIFO_RD_STREAM_CNT_EN is undefined, the beat_cnt port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 Scenario 1: FIFO holds 0x10..0x13 and m_ready=1 -> m_data=0x10,0x11,0x12,0x13 on 4 consecutive cycles, with the first m_valid 2 cycles after the first pop.
REQ-033 Scenario 2: m_ready=0 with the FIFO holding 0x10..0x13 -> exactly 3 pops, level=3, and m_data held at 0x10; m_ready then rises -> 0x10..0x13 delivered in order.
REQ-034 Scenario 3: m_ready toggles 1,0,1,0 with 4 entries -> every beat is delivered once and in order, with no duplicates or drops.
REQ-035 Scenario 4: rstn is pulsed low the cycle after a pop of 0x11 -> level=0 and m_valid=0 immediately, and 0x11 never appears on m_data.
REQ-036 Scenario 5: FIFO is empty -> fifo_pop=0 and m_valid=0 indefinitely; a single push of 0xA5 -> m_data=0xA5 after the pop plus 2 cycles.
REQ-037 Scenario 6 (CNT_EN): 65537 beats are streamed -> beat_cnt=0x0001.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Converts the pop/empty read side of a sync_fifo into a valid/ready stream via a 3-entry skid buffer.
// Optional accepted-beat counter port beat_cnt is built when FIFO_RD_STREAM_CNT_EN is defined.
module fifo_rd_stream #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_dout,
  output logic          fifo_pop,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    level
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [15:0]   beat_cnt
`endif
);

  logic [DW-1:0] mem [3];
  logic [1:0]    wr_ptr;
  logic [1:0]    rd_ptr;
  logic [1:0]    level_q;
  logic          infl;
  logic          run;
  logic          hs;
  logic [2:0]    occ;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // run holds pops off until the first clock edge after reset release
  assign occ      = {1'b0, level_q} + {2'b00, infl};
  assign fifo_pop = run & ~fifo_empty & (occ < 3'd3);
  assign m_valid  = (level_q != 2'd0);
  assign m_data   = mem[rd_ptr];
  assign level    = level_q;
  assign hs       = m_valid & m_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      run     <= 1'b0;
      infl    <= 1'b0;
      wr_ptr  <= 2'd0;
      rd_ptr  <= 2'd0;
      level_q <= 2'd0;
      mem[0]  <= '0;
      mem[1]  <= '0;
      mem[2]  <= '0;
    end else begin
      run  <= 1'b1;
      infl <= fifo_pop;
      if (infl) begin
        mem[wr_ptr] <= fifo_dout;
        wr_ptr      <= inc3(wr_ptr);
      end
      if (hs) begin
        rd_ptr <= inc3(rd_ptr);
      end
      case ({infl, hs})
        2'b10:   level_q <= level_q + 2'd1;
        2'b01:   level_q <= level_q - 2'd1;
        default: level_q <= level_q;
      endcase
    end
  end

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt <= 16'd0;
    end else if (hs) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream: a queue-based sync_fifo model feeds the DUT, a monitor checks stream order.
module tb_fifo_rd_stream;

  logic       clk;
  logic       rstn;
  logic       fifo_empty;
  logic [7:0] fifo_dout;
  logic       fifo_pop;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [1:0] level;
`ifdef FIFO_RD_STREAM_CNT_EN
  logic [15:0] beat_cnt;
`endif

  fifo_rd_stream #(.DW(8)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_pop   (fifo_pop),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .level      (level)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt   (beat_cnt)
`endif
  );

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int  n_pass = 0;
  int  n_total = 0;
  int  outstanding = 0;
  int  pop_cnt = 0;
  int  delivered = 0;
  bit  last_pop = 0;
  bit  prev_stall = 0;
  logic [7:0] prev_data = 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Upstream sync_fifo model: data appears on fifo_dout the cycle after the pop.
  always @(posedge clk) begin
    if (rstn) begin
      if (fifo_pop) begin
        check("pop_not_empty", 32'(fifo_q.size() != 0), 32'd1);
        check("no_overflow", 32'(outstanding < 3), 32'd1);
        if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
        pop_cnt++;
      end
      outstanding = outstanding + int'(fifo_pop) - int'(m_valid && m_ready);
      last_pop = fifo_pop;
    end
  end

  // Monitor: everything popped but not yet delivered, minus the word still in transit, sits in the buffer.
  always @(negedge clk) begin
    if (rstn) begin
      check("level_model", 32'(level), 32'(outstanding - int'(last_pop)));
      check("valid_vs_level", 32'(m_valid), 32'(outstanding - int'(last_pop) != 0));
      if (fifo_empty) check("no_pop_when_empty", 32'(fifo_pop), 32'd0);
      if (prev_stall && m_valid) check("hold_while_stalled", 32'(m_data), 32'(prev_data));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          check("stream_data", 32'(m_data), 32'(exp_q.pop_front()));
        end
        delivered++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
    end
  end

  task automatic push(input logic [7:0] v);
    fifo_q.push_back(v);
    exp_q.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Called at posedge+#1; anything popped or buffered is lost, the FIFO contents remain.
  task automatic assert_reset();
    rstn = 1'b0;
    exp_q = fifo_q;
    outstanding = 0;
    last_pop = 0;
    prev_stall = 0;
    pop_cnt = 0;
    delivered = 0;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_pop", 32'(fifo_pop), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check("rst_beat_cnt", 32'(beat_cnt), 32'd0);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic full_reset();
    cycle();
    assert_reset();
    cycle();
    cycle();
    rstn = 1'b1;
    check("pop_held_until_edge", 32'(fifo_pop), 32'd0);
    cycle();
  endtask

  task automatic wait_drain(input string nm, input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (exp_q.size() == 0 && level == 2'd0) break;
      cycle();
    end
    check(nm, 32'(exp_q.size()), 32'd0);
    check({nm, "_level"}, 32'(level), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
    check({nm, "_beat_cnt"}, 32'(beat_cnt), 32'(delivered[15:0]));
`endif
  endtask

  initial begin
    rstn = 1'b0;
    m_ready = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout = 8'h00;
    full_reset();

    // Two-cycle latency then one beat per cycle
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    #1 check("s1_pop_cycle_n", 32'(fifo_pop), 32'd1);
    cycle();
    check("s1_valid_n1", 32'(m_valid), 32'd0);
    cycle();
    check("s1_valid_n2", 32'(m_valid), 32'd1);
    check("s1_data_n2", 32'(m_data), 32'h10);
    for (int i = 1; i < 4; i++) begin
      cycle();
      check("s1_valid_stream", 32'(m_valid), 32'd1);
      check("s1_data_stream", 32'(m_data), 32'(8'h10 + i));
    end
    wait_drain("s1_drain", 50);

    // Backpressure: three pops fill the buffer, head held
    full_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
    repeat (8) cycle();
    check("s2_pops", 32'(pop_cnt), 32'd3);
    check("s2_level", 32'(level), 32'd3);
    check("s2_head", 32'(m_data), 32'h10);
    check("s2_fifo_left", 32'(fifo_q.size()), 32'd1);
    m_ready = 1'b1;
    wait_drain("s2_drain", 50);

    // Toggling ready
    full_reset();
    for (int i = 0; i < 4; i++) push(8'(8'h20 + i));
    for (int i = 0; i < 40; i++) begin
      m_ready = (i % 2 == 0);
      if (exp_q.size() == 0) break;
      cycle();
    end
    m_ready = 1'b1;
    wait_drain("s3_drain", 20);
    check("s3_beats", 32'(delivered), 32'd4);

    // Reset one cycle after 0x11 is popped
    full_reset();
    m_ready = 1'b1;
    push(8'h10); push(8'h11); push(8'h12);
    cycle();
    cycle();
    assert_reset();
    cycle();
    rstn = 1'b1;
    wait_drain("s4_drain", 30);
    check("s4_beats", 32'(delivered), 32'd1);

    // Idle with empty FIFO, then a single push
    full_reset();
    m_ready = 1'b1;
    repeat (20) cycle();
    check("s5_idle_pop", 32'(fifo_pop), 32'd0);
    check("s5_idle_valid", 32'(m_valid), 32'd0);
    push(8'hA5);
    #1 check("s5_pop", 32'(fifo_pop), 32'd1);
    cycle();
    check("s5_valid_n1", 32'(m_valid), 32'd0);
    cycle();
    check("s5_valid_n2", 32'(m_valid), 32'd1);
    check("s5_data_n2", 32'(m_data), 32'hA5);
    wait_drain("s5_drain", 20);

    // Randomized traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        assert_reset();
        cycle();
        rstn = 1'b1;
      end
      if ($urandom_range(0, 9) < 5) push(8'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    m_ready = 1'b1;
    wait_drain("rand_drain", 2000);

`ifdef FIFO_RD_STREAM_CNT_EN
    // Counter wrap: 65537 beats leave beat_cnt at 1
    full_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 65537; i++) push(8'($urandom));
    wait_drain("s6_drain", 66000);
    check("s6_beat_cnt", 32'(beat_cnt), 32'h0001);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
